// File: rtl/uart_frame_parser_if.sv
// Payload output stream of the frame parser: byte, valid/ready handshake and end-of-packet marker.
interface uart_frame_parser_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/uart_frame_parser.sv
// Hunts for a sync byte, then parses LEN, payload and XOR checksum from the uart_rx byte stream.
// A payload is buffered and released on the output stream only once its checksum matches.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes into the buffer
// CSUM    | waiting for the XOR checksum byte
// DRAIN   | releasing the buffered payload on the output stream
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_framing_error,
  uart_frame_parser_if.master        out,
  output logic                       pkt_done,
  output logic                       err_valid,
  output logic [2:0]                 err_code
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [2:0] E_FRAMING = 3'd0;
  localparam logic [2:0] E_BAD_LEN = 3'd1;
  localparam logic [2:0] E_CSUM    = 3'd2;
  localparam logic [2:0] E_OVERRUN = 3'd3;
  localparam logic [2:0] E_TIMEOUT = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] last_idx;
  logic [7:0]    csum;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    pbuf [MAX_LEN];

  logic drain;
  logic rd_at_last;

  assign drain      = (state == S_DRAIN);
  assign rd_at_last = (rd_idx == last_idx);

  // Output stream is a pure function of registered state, so in_* never reaches it combinationally.
  assign out.valid = drain;
  assign out.data  = drain ? pbuf[rd_idx] : 8'h00;
  assign out.last  = drain && rd_at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_idx    <= '0;
      rd_idx    <= '0;
      last_idx  <= '0;
      csum      <= 8'h00;
      tmo_cnt   <= '0;
      pkt_done  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= E_FRAMING;
    end else begin
      pkt_done  <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (in_valid && !in_framing_error && in_data == SYNC_BYTE)
            state <= S_LEN;
        end

        S_LEN, S_PAYLOAD, S_CSUM: begin
          if (in_valid) begin
            tmo_cnt <= '0;
            if (in_framing_error) begin
              err_valid <= 1'b1;
              err_code  <= E_FRAMING;
              state     <= S_IDLE;
            end else if (state == S_LEN) begin
              if (in_data == 8'h00 || in_data > MAX_LEN_B) begin
                err_valid <= 1'b1;
                err_code  <= E_BAD_LEN;
                state     <= S_IDLE;
              end else begin
                last_idx <= IW'(in_data - 8'd1);
                csum     <= in_data;
                wr_idx   <= '0;
                state    <= S_PAYLOAD;
              end
            end else if (state == S_PAYLOAD) begin
              csum   <= csum ^ in_data;
              wr_idx <= wr_idx + IW'(1);
              if (wr_idx == last_idx)
                state <= S_CSUM;
            end else begin
              if (in_data == csum) begin
                rd_idx <= '0;
                state  <= S_DRAIN;
              end else begin
                err_valid <= 1'b1;
                err_code  <= E_CSUM;
                state     <= S_IDLE;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // The count would reach TIMEOUT_CYCLES on this edge.
            tmo_cnt   <= '0;
            err_valid <= 1'b1;
            err_code  <= E_TIMEOUT;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_DRAIN: begin
          tmo_cnt <= '0;
          if (in_valid) begin
            err_valid <= 1'b1;
            err_code  <= E_OVERRUN;
          end
          if (out.ready) begin
            if (rd_at_last) begin
              state    <= S_IDLE;
              pkt_done <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; contents are only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && in_valid && !in_framing_error)
      pbuf[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good frames, backpressure, checksum/length/framing/timeout
// errors, reset mid-frame and overrun during drain.
module tb_uart_frame_parser;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_fe;
  logic       pkt_done;
  logic       err_valid;
  logic [2:0] err_code;

  uart_frame_parser_if out_if ();

  uart_frame_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_framing_error (in_fe),
    .out              (out_if),
    .pkt_done         (pkt_done),
    .err_valid        (err_valid),
    .err_code         (err_code)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  int         n_pkt = 0;
  int         n_errp = 0;
  int         pb;
  int         eb;
  logic [7:0] rx_data [$];
  logic       rx_last [$];
  logic [7:0] exp_q [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Mid-cycle monitor: handshakes, pulses and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q && out_if.valid) begin
        chk("stall_data", out_if.data, stall_data);
        chk("stall_last", out_if.last, stall_last);
      end
      stall_q    <= out_if.valid && !out_if.ready;
      stall_data <= out_if.data;
      stall_last <= out_if.last;
      if (out_if.valid && out_if.ready) begin
        rx_data.push_back(out_if.data);
        rx_last.push_back(out_if.last);
      end
      if (pkt_done)  n_pkt  <= n_pkt + 1;
      if (err_valid) n_errp <= n_errp + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe = 1'b0);
    in_data  = b;
    in_fe    = fe;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    in_fe    = 1'b0;
  endtask

  task automatic send_good3();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
  endtask

  task automatic expect_good3();
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_len"}, rx_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      chk({tag, "_data"}, rx_data[i], exp_q[i]);
      chk({tag, "_last"}, rx_last[i], (i == exp_q.size() - 1) ? 1 : 0);
    end
    rx_data.delete();
    rx_last.delete();
  endtask

  task automatic wait_pkt(input string tag, input int base);
    int budget;
    budget = 200;
    while (n_pkt == base && budget > 0) begin
      step(1);
      budget--;
    end
    step(3);
    chk({tag, "_pkt"}, n_pkt - base, 1);
  endtask

  task automatic expect_err(input string tag, input logic [2:0] code);
    chk({tag, "_ev"}, err_valid, 1);
    chk({tag, "_ec"}, err_code, code);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_fe = 1'b0; in_data = 8'h00; out_if.ready = 1'b1;
    step(3);
    chk("rst_valid", out_if.valid, 0);
    chk("rst_last",  out_if.last, 0);
    chk("rst_data",  out_if.data, 0);
    chk("rst_done",  pkt_done, 0);
    chk("rst_ev",    err_valid, 0);
    chk("rst_ec",    err_code, 0);
    rst = 1'b0;
    step(2);

    // Good frame, free-flowing consumer.
    expect_good3(); pb = n_pkt;
    send_good3();
    chk("s1_rel",   out_if.valid, 1);
    chk("s1_first", out_if.data, 8'h11);
    wait_pkt("s1", pb);
    check_rx("s1");
    chk("s1_errs", n_errp, 0);

    // Backpressure: one accept, long stall, then alternating ready.
    out_if.ready = 1'b0; expect_good3(); pb = n_pkt;
    send_good3();
    step(2);
    chk("s2_hold", out_if.valid, 1);
    out_if.ready = 1'b1; step(1);
    out_if.ready = 1'b0; step(5);
    for (int i = 0; i < 8; i++) begin
      out_if.ready = i[0];
      step(1);
    end
    out_if.ready = 1'b1;
    wait_pkt("s2", pb);
    check_rx("s2");

    // Bad checksum (FD expected, 00 sent), then clean delivery.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h00);
    expect_err("s3", 3'd2);
    chk("s3_novalid", out_if.valid, 0);
    step(3);
    chk("s3_nodata", rx_data.size(), 0);
    chk("s3_errs", n_errp, 1);
    expect_good3(); pb = n_pkt;
    send_good3();
    wait_pkt("s3b", pb);
    check_rx("s3b");

    // Length errors and sync hunting.
    send_byte(8'hA5); send_byte(8'h00);
    expect_err("s4a", 3'd1);
    send_byte(8'hA5); send_byte(8'h11);
    expect_err("s4b", 3'd1);
    step(4);
    chk("s4_hold", err_code, 1);
    eb = n_errp; pb = n_pkt;
    exp_q.delete(); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hC3); send_byte(8'h9B);
    wait_pkt("s4c", pb);
    check_rx("s4c");
    chk("s4c_errs", n_errp - eb, 0);

    // Framing error inside a frame.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    send_byte(8'h22, 1'b1);
    expect_err("s5a", 3'd0);
    step(2);

    // Inter-byte timeout.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    k = 0;
    while (!err_valid && k < TMO + 5) begin
      step(1);
      k++;
    end
    chk("s5_tmo_cyc", k, TMO);
    chk("s5_tmo_ec", err_code, 4);
    step(2);

    // Reset in the middle of PAYLOAD.
    eb = n_errp;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1;
    step(1);
    chk("s5r_valid", out_if.valid, 0);
    chk("s5r_last",  out_if.last, 0);
    chk("s5r_data",  out_if.data, 0);
    chk("s5r_ev",    err_valid, 0);
    chk("s5r_ec",    err_code, 0);
    rst = 1'b0;
    step(2);
    chk("s5r_errs", n_errp - eb, 0);
    expect_good3(); pb = n_pkt;
    send_good3();
    wait_pkt("s5r", pb);
    check_rx("s5r");

    // Overrun: sync byte arrives while the previous payload is still draining.
    out_if.ready = 1'b0; expect_good3(); pb = n_pkt;
    send_good3();
    send_byte(8'hA5);
    expect_err("s6", 3'd3);
    chk("s6_valid", out_if.valid, 1);
    step(2);
    out_if.ready = 1'b1;
    wait_pkt("s6", pb);
    check_rx("s6");
    exp_q.delete(); exp_q.push_back(8'h7E); pb = n_pkt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    wait_pkt("s6b", pb);
    check_rx("s6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
